// File: rtl/imm_ext_pkg.sv
// Shared types and the extension function for imm_ext_pipe.
// Mode and storage-state enums live here so the pipe and the calc block agree on encodings.
package imm_ext_pkg;

    // Widest immediate/result the extension function handles.
    localparam int unsigned EXT_MAX_W = 64;

    typedef enum logic [1:0] {
        EXT_ZERO   = 2'b00,
        EXT_SIGN   = 2'b01,
        EXT_UPPER  = 2'b10,
        EXT_BRANCH = 2'b11
    } ext_mode_e;

    typedef enum logic [1:0] {
        StEmpty = 2'b00,
        StOne   = 2'b01,
        StTwo   = 2'b10
    } state_e;

    // Extends the low in_w bits of imm into an out_w-bit result (upper bits of the return are 0).
    function automatic logic [EXT_MAX_W-1:0] ext_calc(
        input logic [EXT_MAX_W-1:0] imm,
        input ext_mode_e            mode,
        input int unsigned          in_w  = 16,
        input int unsigned          out_w = 32
    );
        logic [EXT_MAX_W-1:0] ones;
        logic [EXT_MAX_W-1:0] in_mask;
        logic [EXT_MAX_W-1:0] out_mask;
        logic [EXT_MAX_W-1:0] zext;
        logic [EXT_MAX_W-1:0] sext;
        logic [EXT_MAX_W-1:0] res;

        ones     = '1;
        in_mask  = ones >> (EXT_MAX_W - in_w);
        out_mask = ones >> (EXT_MAX_W - out_w);
        zext     = imm & in_mask;
        // Field MSB is set exactly when the zero-extended value exceeds the half-range mask.
        sext     = (zext > (in_mask >> 1)) ? (zext | ~in_mask) : zext;

        unique case (mode)
            EXT_ZERO:   res = zext;
            EXT_SIGN:   res = sext;
            EXT_UPPER:  res = zext << (out_w - in_w);
            EXT_BRANCH: res = sext << 2;
            default:    res = '0;
        endcase

        return res & out_mask;
    endfunction

endpackage

// File: rtl/imm_ext_calc.sv
// Combinational immediate extension (zero, sign, upper, branch) on the pipe's input path.
// Legal configurations satisfy IN_W + 2 <= OUT_W <= EXT_MAX_W.
module imm_ext_calc
    import imm_ext_pkg::*;
#(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 32
) (
    input  logic [IN_W-1:0]  imm_i,
    input  ext_mode_e        mode_i,
    output logic [OUT_W-1:0] ext_o
);

    logic [EXT_MAX_W-1:0] imm_wide;

    always_comb begin
        imm_wide = EXT_MAX_W'(imm_i);
        ext_o    = OUT_W'(ext_calc(imm_wide, mode_i, IN_W, OUT_W));
    end

endmodule

// File: rtl/imm_ext_pipe.sv
// One-cycle registered immediate extender with valid/ready on both sides.
// Define IMM_EXT_SKID_EN for a skid entry and registered in_ready (full throughput under stall).
module imm_ext_pipe
    import imm_ext_pkg::*;
#(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 32,
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_imm,
    output logic [TAG_W-1:0] out_tag
);

    logic [OUT_W-1:0] ext_imm;

    imm_ext_calc #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_calc (
        .imm_i  (in_imm),
        .mode_i (ext_mode_e'(in_mode)),
        .ext_o  (ext_imm)
    );

    state_e           state_q, state_d;
    logic [OUT_W-1:0] main_imm_q, main_imm_d;
    logic [TAG_W-1:0] main_tag_q, main_tag_d;
    logic             in_hs;
    logic             out_hs;

    assign out_valid = (state_q != StEmpty);
    assign out_imm   = main_imm_q;
    assign out_tag   = main_tag_q;
    assign in_hs     = in_valid && in_ready;
    assign out_hs    = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StEmpty;
            main_imm_q <= '0;
            main_tag_q <= '0;
        end else begin
            state_q    <= state_d;
            main_imm_q <= main_imm_d;
            main_tag_q <= main_tag_d;
        end
    end

`ifdef IMM_EXT_SKID_EN

    logic [OUT_W-1:0] skid_imm_q, skid_imm_d;
    logic [TAG_W-1:0] skid_tag_q, skid_tag_d;
    logic             in_ready_q, in_ready_d;

    assign in_ready = in_ready_q;

    always_comb begin
        state_d    = state_q;
        main_imm_d = main_imm_q;
        main_tag_d = main_tag_q;
        skid_imm_d = skid_imm_q;
        skid_tag_d = skid_tag_q;

        unique case (state_q)
            StEmpty: begin
                if (in_hs) begin
                    main_imm_d = ext_imm;
                    main_tag_d = in_tag;
                    state_d    = StOne;
                end
            end
            StOne: begin
                if (in_hs && out_hs) begin
                    main_imm_d = ext_imm;
                    main_tag_d = in_tag;
                end else if (in_hs) begin
                    // Consumer stalled: park the new result behind the one on display.
                    skid_imm_d = ext_imm;
                    skid_tag_d = in_tag;
                    state_d    = StTwo;
                end else if (out_hs) begin
                    state_d    = StEmpty;
                end
            end
            StTwo: begin
                if (out_hs) begin
                    main_imm_d = skid_imm_q;
                    main_tag_d = skid_tag_q;
                    state_d    = StOne;
                end
            end
            default: state_d = StEmpty;
        endcase

        in_ready_d = (state_d != StTwo);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_imm_q <= '0;
            skid_tag_q <= '0;
            in_ready_q <= 1'b0;
        end else begin
            skid_imm_q <= skid_imm_d;
            skid_tag_q <= skid_tag_d;
            in_ready_q <= in_ready_d;
        end
    end

`else

    // Holds in_ready low through reset and until the first edge after release.
    logic rst_done_q;

    assign in_ready = rst_done_q && (!out_valid || out_ready);

    always_comb begin
        state_d    = state_q;
        main_imm_d = main_imm_q;
        main_tag_d = main_tag_q;

        unique case (state_q)
            StEmpty: begin
                if (in_hs) begin
                    main_imm_d = ext_imm;
                    main_tag_d = in_tag;
                    state_d    = StOne;
                end
            end
            StOne: begin
                if (in_hs) begin
                    main_imm_d = ext_imm;
                    main_tag_d = in_tag;
                end else if (out_hs) begin
                    state_d    = StEmpty;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_done_q <= 1'b0;
        end else begin
            rst_done_q <= 1'b1;
        end
    end

`endif

endmodule
